// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
// Packet layout: {result[15:0], R1 tag[4:0], R0 tag[4:0]}.
package wb_pkg;

    localparam int RES_W   = 26;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 5;
    localparam int NUM_SRC = 3;

    typedef logic [RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        SRC_A0 = 2'd0,
        SRC_A1 = 2'd1,
        SRC_M  = 2'd2
    } src_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer-side and writeback-bus handshake signals of the writeback arbiter.
// slave: the arbiter's view; master: the execute stage / consumer view.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic       a0_valid;
    res_t       a0_res;
    logic       a0_ready;
    logic       a1_valid;
    res_t       a1_res;
    logic       a1_ready;
    logic       m_valid;
    res_t       m_res;
    logic       m_ready;
    logic       wb_valid;
    res_t       wb_res;
    logic [1:0] wb_src;
    logic       wb_ready;

    modport slave (
        input  a0_valid, a0_res, a1_valid, a1_res, m_valid, m_res, wb_ready,
        output a0_ready, a1_ready, m_ready, wb_valid, wb_res, wb_src
    );

    modport master (
        output a0_valid, a0_res, a1_valid, a1_res, m_valid, m_res, wb_ready,
        input  a0_ready, a1_ready, m_ready, wb_valid, wb_res, wb_src
    );

endinterface

// File: rtl/wb_fifo.sv
// Per-source packet FIFO. DEPTH must be a power of two so the pointers wrap
// naturally; count runs 0..DEPTH. The caller gates push with !full and pop
// with !empty.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    assign dout  = mem_q[rptr_q];
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(DEPTH));

    // Next pointer / occupancy values from this cycle's push and pop.
    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // Pointer and count state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one FIFO per execute unit (A0, A1, M), round-robin
// selection into a registered valid/ready output.
// Optional macro WB_BYPASS_EN: an empty FIFO whose producer is pushing may
// win arbitration directly, giving 1-cycle latency instead of 2.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = wb_pkg::RES_W
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);
    logic [NUM_SRC-1:0] in_valid;
    res_t               in_res   [NUM_SRC];
    res_t               fifo_dout[NUM_SRC];
    logic [NUM_SRC-1:0] empty, full;
    logic [NUM_SRC-1:0] push, fifo_push, pop, byp, cand;

    logic [1:0] gsel;
    logic       any_cand;
    logic       load;
    res_t       load_res;

    logic       wb_valid_q, wb_valid_d;
    res_t       wb_res_q,   wb_res_d;
    logic [1:0] wb_src_q,   wb_src_d;
    src_e       last_grant_q, last_grant_d;

    assign in_valid  = {bus.m_valid, bus.a1_valid, bus.a0_valid};
    assign in_res[0] = bus.a0_res;
    assign in_res[1] = bus.a1_res;
    assign in_res[2] = bus.m_res;

    // Ready depends only on registered occupancy: a full FIFO refuses a
    // push even in a cycle where it is being popped.
    assign bus.a0_ready = !full[0];
    assign bus.a1_ready = !full[1];
    assign bus.m_ready  = !full[2];

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_res   = wb_res_q;
    assign bus.wb_src   = wb_src_q;

    assign push      = in_valid & ~full;
    assign fifo_push = push & ~byp;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        wb_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (fifo_push[g]),
            .din   (in_res[g]),
            .pop   (pop[g]),
            .dout  (fifo_dout[g]),
            .empty (empty[g]),
            .full  (full[g])
        );
    end

    // Candidate set; a source with buffered packets never bypasses so its
    // order is preserved.
    always_comb begin
`ifdef WB_BYPASS_EN
        cand = ~empty | (empty & push);
`else
        cand = ~empty;
`endif
    end

    // Round-robin search starting at the source after last_grant.
    always_comb begin
        int idx;
        gsel     = 2'(last_grant_q);
        any_cand = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            idx = (int'(last_grant_q) + i) % NUM_SRC;
            if (!any_cand && cand[idx]) begin
                any_cand = 1'b1;
                gsel     = 2'(idx);
            end
        end
    end

    assign load = (!wb_valid_q || bus.wb_ready) && any_cand;

    // Winner pops its FIFO, or on bypass takes the packet straight off its input.
    always_comb begin
        pop = '0;
        byp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (load && gsel == 2'(i)) begin
`ifdef WB_BYPASS_EN
                byp[i] = empty[i] && push[i];
`endif
                pop[i] = !empty[i];
            end
        end
        load_res = byp[gsel] ? in_res[gsel] : fifo_dout[gsel];
    end

    // Output register next state: load, drain to idle, or hold while stalled.
    always_comb begin
        wb_valid_d   = wb_valid_q;
        wb_res_d     = wb_res_q;
        wb_src_d     = wb_src_q;
        last_grant_d = last_grant_q;
        if (load) begin
            wb_valid_d   = 1'b1;
            wb_res_d     = load_res;
            wb_src_d     = gsel;
            last_grant_d = src_e'(gsel);
        end else if (bus.wb_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; A0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            wb_res_q     <= '0;
            wb_src_q     <= 2'd0;
            last_grant_q <= SRC_M;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_res_q     <= wb_res_d;
            wb_src_q     <= wb_src_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus pushes expected packets, a
// negedge monitor pops and compares on every writeback transfer.
module tb_wb_arbiter;
    import wb_pkg::*;

`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.DEPTH(4), .RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        res_t       res;
        logic [1:0] src;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int s, input logic v, input res_t r);
        case (s)
            0:       begin bus.a0_valid = v; bus.a0_res = r; end
            1:       begin bus.a1_valid = v; bus.a1_res = r; end
            default: begin bus.m_valid  = v; bus.m_res  = r; end
        endcase
    endtask

    function automatic logic rdy(input int s);
        case (s)
            0:       return bus.a0_ready;
            1:       return bus.a1_ready;
            default: return bus.m_ready;
        endcase
    endfunction

    task automatic expect_pkt(input res_t r, input int s);
        exp_t e;
        e.res = r;
        e.src = 2'(s);
        sb.push_back(e);
    endtask

    // Offer one packet, hold it until accepted; returns at edge+1.
    task automatic send(input int s, input res_t r);
        logic ok;
        ok = 1'b0;
        set_in(s, 1'b1, r);
        for (int k = 0; k < 50; k++) begin
            ok = rdy(s);
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: src %0d got no ready expected accept", s);
        end
        set_in(s, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(posedge clk);
        #1 chk(nm, sb.size(), 0);
    endtask

    // Monitor: compares every transfer and checks stability across stalls.
    initial begin
        logic       stall_q;
        res_t       stall_res;
        logic [1:0] stall_src;
        exp_t       e;
        stall_q = 1'b0;
        stall_res = '0;
        stall_src = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (stall_q) begin
                    chk("stall_res", bus.wb_res, stall_res);
                    chk("stall_src", bus.wb_src, stall_src);
                end
                if (bus.wb_valid && bus.wb_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_xfer: got res %h src %0d expected none",
                                 bus.wb_res, bus.wb_src);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_res", bus.wb_res, e.res);
                        chk("sb_src", bus.wb_src, e.src);
                    end
                end
                stall_q   = bus.wb_valid && !bus.wb_ready;
                stall_res = bus.wb_res;
                stall_src = bus.wb_src;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t p[6];
        rst = 1'b1;
        bus.wb_ready = 1'b0;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, '0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // T1: asynchronous mid-cycle reset while a packet is stalled.
        send(0, 26'h1111111);
        repeat (3) @(posedge clk);
        #1 chk("t1_pre_valid", bus.wb_valid, 1);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        chk("t1_valid", bus.wb_valid, 0);
        chk("t1_res", bus.wb_res, 0);
        chk("t1_src", bus.wb_src, 0);
        chk("t1_a0_ready", bus.a0_ready, 1);
        chk("t1_a1_ready", bus.a1_ready, 1);
        chk("t1_m_ready", bus.m_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // T2: single A0 packet latency.
        bus.wb_ready = 1'b1;
        expect_pkt(26'h2ABCDEF, 0);
        send(0, 26'h2ABCDEF);
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", bus.wb_valid, (k == LAT - 1) ? 1 : 0);
            if (k == LAT - 1) begin
                chk("t2_res", bus.wb_res, 26'h2ABCDEF);
                chk("t2_src", bus.wb_src, 0);
            end
            @(posedge clk); #1;
        end

        // T3: all three sources push together; A0, A1, M back to back.
        do_reset();
        bus.wb_ready = 1'b1;
        expect_pkt(26'h0000A0A, 0);
        expect_pkt(26'h0000A1A, 1);
        expect_pkt(26'h0000B0B, 2);
        set_in(0, 1'b1, 26'h0000A0A);
        set_in(1, 1'b1, 26'h0000A1A);
        set_in(2, 1'b1, 26'h0000B0B);
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) set_in(s, 1'b0, '0);
        for (int k = 0; k < LAT + 3; k++) begin
            chk("t3_valid", bus.wb_valid,
                (k >= LAT - 1 && k <= LAT + 1) ? 1 : 0);
            if (k >= LAT - 1 && k <= LAT + 1)
                chk("t3_src", bus.wb_src, k - (LAT - 1));
            @(posedge clk); #1;
        end

        // T4: backpressure fills A0: P1 in output, P2..P5 in FIFO, P6 held.
        do_reset();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            p[i] = 26'h3000001 + 26'(i);
            expect_pkt(p[i], 0);
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_open", bus.a0_ready, 1);
            set_in(0, 1'b1, p[i]);
            @(posedge clk); #1;
        end
        set_in(0, 1'b1, p[5]);
        for (int k = 0; k < 3; k++) begin
            chk("t4_ready_full", bus.a0_ready, 0);
            chk("t4_hold_res", bus.wb_res, p[0]);
            @(posedge clk); #1;
        end
        bus.wb_ready = 1'b1;
        send(0, p[5]);
        wait_drain("t4_drain");

        // T5: A0 and M streaming, fair alternation at full throughput.
        do_reset();
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_pkt(26'h0A00000 + 26'(i), 0);
            expect_pkt(26'h0C00000 + 26'(i), 2);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 26'h0A00000 + 26'(i));
            end
            begin
                for (int i = 0; i < 4; i++) send(2, 26'h0C00000 + 26'(i));
            end
            begin
                for (int k = 0; k < 10 && !bus.wb_valid; k++) @(negedge clk);
                chk("t5_first_valid", bus.wb_valid, 1);
                for (int k = 0; k < 7; k++) begin
                    @(negedge clk);
                    chk("t5_stream_valid", bus.wb_valid, 1);
                end
            end
        join
        wait_drain("t5_drain");

        // T6: reset discards buffered A1 packets.
        do_reset();
        bus.wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 26'h1B00000 + 26'(i));
        chk("t6_pre_valid", bus.wb_valid, 1);
        rst = 1'b1;
        #1 chk("t6_rst_valid", bus.wb_valid, 0);
        @(posedge clk); #1 rst = 1'b0;
        bus.wb_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("t6_valid", bus.wb_valid, 0);
            chk("t6_a1_ready", bus.a1_ready, 1);
            @(posedge clk); #1;
        end

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Writeback stage directly downstream of the execute stage. Collects 26-bit result packets from the A0, A1 and M units. Each packet is {result[15:0], R1 tag[4:0], R0 tag[4:0]}.
- Buffers each source in its own small FIFO.
- Issues one packet per cycle onto the writeback bus, using round-robin arbitration and a valid/ready handshake.

Parameters:
DEPTH, 4, entries per source FIFO; must be a power of 2, at least 2
RES_W, 26, packet width, matching the execute result format

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
a0_valid  input  1  A0 packet valid
a0_res  input  26  A0 packet
a0_ready  output  1  A0 FIFO can accept
a1_valid  input  1  A1 packet valid
a1_res  input  26  A1 packet
a1_ready  output  1  A1 FIFO can accept
m_valid  input  1  M packet valid
m_res  input  26  M packet
m_ready  output  1  M FIFO can accept
wb_valid  output  1  writeback bus packet valid
wb_res  output  26  writeback packet, unmodified from source
wb_src  output  2  packet source: 0 = A0, 1 = A1, 2 = M
wb_ready  input  1  consumer accepts packet

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - wb_valid=0, wb_res=0, wb_src=0.
  - All FIFO counts and pointers are 0.
  - Round-robin pointer is last_grant=M, so A0 has first priority.
  - x_ready = 1 during and after reset.
- Push: a source pushes on a rising edge when x_valid && x_ready.
  - x_ready = (count_x != DEPTH), derived from registered count only.
  - A full FIFO refuses a push even in a cycle where it pops.
  - The producer holds valid/res while ready is low; the input is ignored when ready=0.
- FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Output register: loads when (!wb_valid || wb_ready) and at least one candidate exists.
  - A candidate is a non-empty FIFO.
  - The winning FIFO pops in the same edge.
  - If no candidate exists and wb_ready=1, wb_valid falls to 0; wb_res holds its last value.
- Handshake:
  - A transfer occurs on an edge with wb_valid && wb_ready.
  - While wb_valid=1 && wb_ready=0, wb_res and wb_src are stable.
- Arbitration:
  - Search order starts at the source after last_grant, with M wrapping to A0.
  - last_grant updates only when the output register loads.
- Latency (no bypass):
  - A packet pushed at edge N is visible on wb_res after edge N+1 at the earliest.
  - That is 2 cycles from input valid to wb_valid.
- Ordering:
  - Per-source order is preserved.
  - Order across sources follows round-robin only.
- Throughput: 1 packet per cycle sustained while wb_ready=1.

Optional Feature:
Macro WB_BYPASS_EN.
- When defined:
  - A source whose FIFO is empty and whose x_valid && x_ready is asserted also counts as a candidate.
  - If it wins arbitration, its packet loads directly into the output register and is not written to the FIFO.
  - Minimum latency is 1 cycle.
  - A source with a non-empty FIFO never bypasses, which preserves order.
- When undefined:
  - Candidates are non-empty FIFOs only.
  - Minimum latency is 2 cycles.

Decomposition:
- Package wb_pkg:
  - RES_W=26, DATA_W=16, TAG_W=5.
  - typedef res_t logic [25:0].
  - Source enum: SRC_A0=0, SRC_A1=1, SRC_M=2.
  - NUM_SRC=3.
- Sub-module wb_fifo (parameter DEPTH):
  - Ports: clk, rst, push, din, pop, dout, empty, full.
  - Instantiated once per source.
- Arbiter and output register live in wb_arbiter.

Test Plan:
1. Assert rst mid-cycle with wb_ready=0 -> wb_valid=0, wb_res=0, wb_src=0 immediately; a0/a1/m_ready=1.
2. Push A0 packet 0x2ABCDEF at edge 0, wb_ready=1 -> wb_valid=1, wb_res=0x2ABCDEF, wb_src=0 after edge 1 (after edge 0 with WB_BYPASS_EN); wb_valid=0 after edge 2.
3. A0, A1 and M each push one packet at edge 0, wb_ready=1 -> outputs in consecutive cycles with wb_src=0, 1, 2.
4. wb_ready=0, A0 pushes 6 packets P1..P6 back-to-back with DEPTH=4:
   - P1..P5 accepted (P1 in the output register, 4 in the FIFO).
   - a0_ready=0 when P6 is offered; P6 held.
   - Raise wb_ready -> P1..P6 emitted in order.
5. A0 and M continuously valid, A1 idle, wb_ready=1 -> wb_src alternates 0, 2, 0, 2; neither source waits more than 1 cycle between grants.
6. 3 packets buffered in A1, assert rst for 1 cycle -> wb_valid=0; after release no packet is emitted and a1_ready=1.
